// File: rtl/serial_add_ctrl.sv
//------------------------------------------------------------------------------
// Module      : serial_add_ctrl (with full_adder cell)
// Description : Bit-serial N-bit adder sequencing one 1-bit full adder LSB-first.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c_in,
    output logic o_s,
    output logic o_c_out
);
    assign o_s     = i_a ^ i_b ^ i_c_in;
    assign o_c_out = (i_a & i_b) | (i_c_in & (i_a ^ i_b));
endmodule

module serial_add_ctrl #(
    parameter int N = 8
) (
    input  logic         clock,
    input  logic         clear,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] sum,
    output logic         cout
);
    localparam int             CW     = $clog2(N) + 1;
    localparam logic [CW-1:0]  c_LAST = CW'(N - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]    r_st;
    logic [N-1:0]  r_a_sh;
    logic [N-1:0]  r_b_sh;
    logic [N-1:0]  r_acc;
    logic          r_carry;
    logic [CW-1:0] r_cnt;
    logic [N-1:0]  r_sum;
    logic          r_cout;
    logic          r_busy;
    logic          r_done;

    logic          w_s;
    logic          w_c;
    logic [N-1:0]  w_a_next;
    logic [N-1:0]  w_b_next;
    logic [N-1:0]  w_acc_next;

    full_adder u_fa (
        .i_a     (r_a_sh[0]),
        .i_b     (r_b_sh[0]),
        .i_c_in  (r_carry),
        .o_s     (w_s),
        .o_c_out (w_c)
    );

    // A single-bit datapath has nothing to shift through, so it needs its own form.
    generate
        if (N > 1) begin : g_wide
            assign w_a_next   = {1'b0, r_a_sh[N-1:1]};
            assign w_b_next   = {1'b0, r_b_sh[N-1:1]};
            assign w_acc_next = {w_s, r_acc[N-1:1]};
        end else begin : g_one
            assign w_a_next   = 1'b0;
            assign w_b_next   = 1'b0;
            assign w_acc_next = w_s;
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (clear) begin
            r_st    <= c_IDLE;
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_st)
                c_IDLE: begin
                    if (start) begin
                        r_a_sh  <= a;
                        r_b_sh  <= b;
                        r_carry <= cin;
                        r_cnt   <= '0;
                        r_st    <= c_RUN;
                        r_busy  <= 1'b1;
                    end
                end
                c_RUN: begin
                    r_a_sh  <= w_a_next;
                    r_b_sh  <= w_b_next;
                    r_acc   <= w_acc_next;
                    r_carry <= w_c;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        r_sum  <= w_acc_next;
                        r_cout <= w_c;
                        r_st   <= c_DONE;
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                    end
                end
                c_DONE: begin
                    r_st   <= c_IDLE;
                    r_done <= 1'b0;
                end
                default: begin
                    r_st   <= c_IDLE;
                    r_busy <= 1'b0;
                    r_done <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
//------------------------------------------------------------------------------
// Module      : tb_serial_add_ctrl
// Description : Directed bench for serial_add_ctrl at N=8, N=2 and N=1.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_serial_add_ctrl;
    logic       clock = 1'b0;
    logic       clear;
    logic       start8, start2, start1;
    logic [7:0] a8, b8;
    logic [1:0] a2, b2;
    logic [0:0] a1, b1;
    logic       cin8, cin2, cin1;
    logic       busy8, busy2, busy1;
    logic       done8, done2, done1;
    logic [7:0] sum8;
    logic [1:0] sum2;
    logic [0:0] sum1;
    logic       cout8, cout2, cout1;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    serial_add_ctrl #(.N(8)) u_dut8 (
        .clock(clock), .clear(clear), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );
    serial_add_ctrl #(.N(2)) u_dut2 (
        .clock(clock), .clear(clear), .start(start2), .a(a2), .b(b2), .cin(cin2),
        .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
    );
    serial_add_ctrl #(.N(1)) u_dut1 (
        .clock(clock), .clear(clear), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] exp_sum;
        logic       exp_cout;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input int w, input logic s, input logic [7:0] a, input logic [7:0] b,
                         input logic c);
        case (w)
            8:       begin start8 = s; a8 = a;      b8 = b;      cin8 = c; end
            2:       begin start2 = s; a2 = a[1:0]; b2 = b[1:0]; cin2 = c; end
            default: begin start1 = s; a1 = a[0];   b1 = b[0];   cin1 = c; end
        endcase
    endtask

    function automatic logic dn(input int w);
        return (w == 8) ? done8 : (w == 2) ? done2 : done1;
    endfunction

    function automatic logic bz(input int w);
        return (w == 8) ? busy8 : (w == 2) ? busy2 : busy1;
    endfunction

    // Accept at the next edge, scrub inputs right after, then measure latency in cycles.
    task automatic run_op(input int w, input logic [7:0] a, input logic [7:0] b, input logic c,
                          output int lat, output int busy_cnt);
        @(negedge clock);
        drive(w, 1'b1, a, b, c);
        @(negedge clock);
        drive(w, 1'b0, ~a, ~b, ~c);
        lat = -1;
        busy_cnt = 0;
        for (int k = 0; k < w + 6; k++) begin
            if (dn(w)) begin
                lat = k;
                break;
            end
            if (bz(w)) busy_cnt++;
            @(negedge clock);
        end
    endtask

    vec_t vecs[9];
    int   lat, bcnt, ndone, prev_idx, width_err, first_done;
    logic prev_d;

    initial begin
        vecs[0] = '{8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'h10, 8'h20, 1'b1, 8'h31, 1'b0};
        vecs[4] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[6] = '{8'h0F, 8'hF0, 1'b1, 8'h00, 1'b1};
        vecs[7] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};
        vecs[8] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};

        // Reset held with start asserted and random operands.
        clear = 1'b1;
        drive(8, 1'b1, 8'($urandom), 8'($urandom), 1'b1);
        drive(2, 1'b1, 8'h3, 8'h2, 1'b1);
        drive(1, 1'b1, 8'h1, 8'h1, 1'b1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            chk("rst_busy", {31'd0, busy8}, 0);
            chk("rst_done", {31'd0, done8}, 0);
            chk("rst_sum",  {24'd0, sum8}, 0);
            chk("rst_cout", {31'd0, cout8}, 0);
        end
        drive(8, 1'b0, 8'h0, 8'h0, 1'b0);
        drive(2, 1'b0, 8'h0, 8'h0, 1'b0);
        drive(1, 1'b0, 8'h0, 8'h0, 1'b0);
        clear = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("post_rst_idle", {30'd0, busy8, done8}, 0);
        end

        foreach (vecs[i]) begin
            run_op(8, vecs[i].a, vecs[i].b, vecs[i].cin, lat, bcnt);
            chk($sformatf("v%0d_latency", i), lat, 8);
            chk($sformatf("v%0d_busy_cycles", i), bcnt, 8);
            chk($sformatf("v%0d_sum", i), {24'd0, sum8}, {24'd0, vecs[i].exp_sum});
            chk($sformatf("v%0d_cout", i), {31'd0, cout8}, {31'd0, vecs[i].exp_cout});
            @(negedge clock);
            chk($sformatf("v%0d_done_width", i), {31'd0, done8}, 0);
        end

        // start pulsed mid-RUN must be neither honoured nor queued.
        @(negedge clock);
        drive(8, 1'b1, 8'h5A, 8'h33, 1'b0);
        ndone = 0;
        first_done = -1;
        for (int k = -1; k < 22; k++) begin
            @(negedge clock);
            drive(8, (k == 2), 8'h01, 8'h01, 1'b0);
            if (done8) begin
                ndone++;
                if (first_done < 0) first_done = k + 1;
            end
        end
        chk("ign_done_count", ndone, 1);
        chk("ign_done_at", first_done, 8);
        chk("ign_sum", {24'd0, sum8}, 32'h8D);
        chk("ign_cout", {31'd0, cout8}, 0);

        // Continuous start: done every N+2 cycles, one cycle wide.
        drive(8, 1'b1, 8'hFF, 8'h01, 1'b0);
        ndone = 0;
        prev_idx = -1;
        width_err = 0;
        prev_d = 1'b0;
        for (int k = 0; k < 42; k++) begin
            @(negedge clock);
            if (done8 && prev_d) width_err++;
            if (done8) begin
                if (prev_idx >= 0) chk("cont_period", k - prev_idx, 10);
                prev_idx = k;
                ndone++;
            end
            prev_d = done8;
        end
        drive(8, 1'b0, 8'h0, 8'h0, 1'b0);
        chk("cont_done_count", ndone, 4);
        chk("cont_width", width_err, 0);
        chk("cont_sum", {23'd0, cout8, sum8}, 32'h100);
        repeat (12) @(negedge clock);

        // Abort on the 4th RUN cycle.
        drive(8, 1'b1, 8'h5A, 8'h33, 1'b0);
        @(negedge clock);
        drive(8, 1'b0, 8'h0, 8'h0, 1'b0);
        repeat (3) @(negedge clock);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        chk("abort_busy", {31'd0, busy8}, 0);
        chk("abort_sum",  {24'd0, sum8}, 0);
        chk("abort_cout", {31'd0, cout8}, 0);
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            if (done8) ndone++;
            @(negedge clock);
        end
        chk("abort_no_done", ndone, 0);
        run_op(8, 8'h10, 8'h20, 1'b1, lat, bcnt);
        chk("after_abort_latency", lat, 8);
        chk("after_abort_result", {23'd0, cout8, sum8}, 32'h031);

        // Exhaustive N=2 and N=1.
        for (int v = 0; v < 32; v++) begin
            logic [1:0] ta, tb;
            logic       tc;
            ta = 2'(v >> 3);
            tb = 2'(v >> 1);
            tc = v[0];
            run_op(2, {6'd0, ta}, {6'd0, tb}, tc, lat, bcnt);
            chk($sformatf("n2_lat_%0d", v), lat, 2);
            chk($sformatf("n2_res_%0d", v), {29'd0, cout2, sum2},
                32'(ta) + 32'(tb) + 32'(tc));
        end
        for (int v = 0; v < 8; v++) begin
            logic ta, tb, tc;
            ta = v[2];
            tb = v[1];
            tc = v[0];
            run_op(1, {7'd0, ta}, {7'd0, tb}, tc, lat, bcnt);
            chk($sformatf("n1_lat_%0d", v), lat, 1);
            chk($sformatf("n1_busy_%0d", v), bcnt, 1);
            chk($sformatf("n1_res_%0d", v), {30'd0, cout1, sum1},
                32'(ta) + 32'(tb) + 32'(tc));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
